// File: rtl/slow_timer_if.sv
// Peripheral bus decode bundle feeding slow_timer: access strobe plus per-device selects.
interface slow_timer_if;
  logic BACT;
  logic IACKCS;
  logic VIACS;
  logic IWMCS;
  logic SCCCS;
  logic SCSICS;
  logic SndCSWR;

  modport master (output BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR);
  modport slave  (input  BACT, IACKCS, VIACS, IWMCS, SCCCS, SCSICS, SndCSWR);
endinterface

// File: rtl/slow_timer.sv
// Slow-mode request generator: accesses to enabled slow devices hold SlowReq for the access
// plus a retriggerable hold-off window. Optional macro SLOW_PRESCALE_EN selects an internal tick.
module slow_timer #(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned PRESCALE = 10
) (
  input  logic               CLK,
  input  logic               POR,
  slow_timer_if.slave        bus,
  input  logic               SlowIACK,
  input  logic               SlowVIA,
  input  logic               SlowIWM,
  input  logic               SlowSCC,
  input  logic               SlowSCSI,
  input  logic               SlowSnd,
  input  logic               SlowClockGate,
  input  logic [3:0]         SlowTimeout,
  input  logic               TimerTick,
  output logic               SlowReq,
  output logic               ClockGate,
  output logic [CNT_W-1:0]   HoldCnt
);

  localparam int unsigned LOW_W = CNT_W - 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_HOLD = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic             r_req, w_req_nxt;
  logic             r_gate, w_gate_nxt;
  logic             r_bact;

  logic             w_tick;
  logic             w_start;
  logic             w_sel;
  logic             w_hit;
  logic [CNT_W-1:0] w_load;
  logic [CNT_W-1:0] w_dec;

`ifdef SLOW_PRESCALE_EN
  // Free-running divider; the tick fires on the cycle it wraps.
  logic [PRESCALE-1:0] r_prescale;
  logic                w_unused;

  always_ff @(posedge CLK) begin
    if (POR) r_prescale <= '0;
    else     r_prescale <= r_prescale + PRESCALE'(1);
  end

  assign w_tick   = (r_prescale == {PRESCALE{1'b1}});
  assign w_unused = TimerTick;
`else
  localparam int unsigned prescale_unused = PRESCALE;

  assign w_tick = TimerTick;
`endif

  assign w_start = bus.BACT && !r_bact;
  assign w_sel   = (bus.IACKCS  && SlowIACK) || (bus.VIACS  && SlowVIA)  ||
                   (bus.IWMCS   && SlowIWM)  || (bus.SCCCS  && SlowSCC)  ||
                   (bus.SCSICS  && SlowSCSI) || (bus.SndCSWR && SlowSnd);
  assign w_hit   = w_start && w_sel;
  assign w_load  = (SlowTimeout == 4'd0) ? '0 : {SlowTimeout, {LOW_W{1'b1}}};
  assign w_dec   = r_cnt - CNT_W'(1);

  always_ff @(posedge CLK) begin
    if (POR) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_req   <= 1'b0;
      r_gate  <= 1'b0;
      r_bact  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_req   <= w_req_nxt;
      r_gate  <= w_gate_nxt;
      r_bact  <= bus.BACT;
    end
  end

  // Window control; a Hit always reloads and takes priority over a tick.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_req_nxt   = r_req;
    w_gate_nxt  = r_gate;
    unique case (r_state)
      ST_IDLE: begin
        if (w_hit) begin
          w_state_nxt = ST_ACC;
          w_cnt_nxt   = w_load;
          w_req_nxt   = 1'b1;
          w_gate_nxt  = SlowClockGate;
        end
      end
      ST_ACC: begin
        if (!bus.BACT) begin
          if (r_cnt != '0) begin
            w_state_nxt = ST_HOLD;
          end else begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
            w_gate_nxt  = 1'b0;
          end
        end
      end
      ST_HOLD: begin
        if (w_hit) begin
          w_state_nxt = ST_ACC;
          w_cnt_nxt   = w_load;
          w_req_nxt   = 1'b1;
          w_gate_nxt  = SlowClockGate;
        end else if (w_tick && (r_cnt != '0)) begin
          w_cnt_nxt = w_dec;
          if (w_dec == '0) begin
            w_state_nxt = ST_IDLE;
            w_req_nxt   = 1'b0;
            w_gate_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
        w_cnt_nxt   = '0;
        w_req_nxt   = 1'b0;
        w_gate_nxt  = 1'b0;
      end
    endcase
  end

  assign SlowReq   = r_req;
  assign ClockGate = r_gate;
  assign HoldCnt   = r_cnt;

endmodule

// File: tb/tb_slow_timer.sv
// Directed plus randomized bench for slow_timer against a window-level reference model.
module tb_slow_timer;

  localparam int unsigned CNT_W = 8;
  localparam int unsigned PSC   = 4;

  logic             CLK = 1'b0;
  logic             POR;
  logic             SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd;
  logic             SlowClockGate;
  logic [3:0]       SlowTimeout;
  logic             TimerTick;
  logic             SlowReq, ClockGate;
  logic [CNT_W-1:0] HoldCnt;

  slow_timer_if bus_if ();

  slow_timer #(.CNT_W(CNT_W), .PRESCALE(PSC)) dut (
    .CLK          (CLK),
    .POR          (POR),
    .bus          (bus_if.slave),
    .SlowIACK     (SlowIACK),
    .SlowVIA      (SlowVIA),
    .SlowIWM      (SlowIWM),
    .SlowSCC      (SlowSCC),
    .SlowSCSI     (SlowSCSI),
    .SlowSnd      (SlowSnd),
    .SlowClockGate(SlowClockGate),
    .SlowTimeout  (SlowTimeout),
    .TimerTick    (TimerTick),
    .SlowReq      (SlowReq),
    .ClockGate    (ClockGate),
    .HoldCnt      (HoldCnt)
  );

  always #5 CLK = ~CLK;

  int vectors    = 0;
  int miscompares = 0;

  // Reference model: a window is "slow" while an access lasts, then for m_rem more ticks.
  bit m_prev, m_slow, m_gate, m_in_access;
  int m_rem, m_pre, m_ticks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    bit start, hit, tick;
    int unit;
    @(posedge CLK);
    unit = 1 << (CNT_W - 4);
    if (POR) begin
      m_prev = 0; m_slow = 0; m_gate = 0; m_in_access = 0; m_rem = 0; m_pre = 0;
    end else begin
      start = bus_if.BACT && !m_prev;
      hit   = start && ((bus_if.IACKCS && SlowIACK) || (bus_if.VIACS && SlowVIA) ||
                        (bus_if.IWMCS && SlowIWM) || (bus_if.SCCCS && SlowSCC) ||
                        (bus_if.SCSICS && SlowSCSI) || (bus_if.SndCSWR && SlowSnd));
`ifdef SLOW_PRESCALE_EN
      tick  = (m_pre == (1 << PSC) - 1);
`else
      tick  = TimerTick;
`endif
      if (tick) m_ticks++;
      m_prev = bus_if.BACT;
      m_pre  = (m_pre + 1) % (1 << PSC);
      if (hit && (!m_slow || !m_in_access)) begin
        m_rem       = (SlowTimeout == 0) ? 0 : (int'(SlowTimeout) + 1) * unit - 1;
        m_slow      = 1;
        m_gate      = SlowClockGate;
        m_in_access = 1;
      end else if (m_slow && m_in_access) begin
        if (!bus_if.BACT) begin
          m_in_access = 0;
          if (m_rem == 0) begin m_slow = 0; m_gate = 0; end
        end
      end else if (m_slow && tick && m_rem > 0) begin
        m_rem--;
        if (m_rem == 0) begin m_slow = 0; m_gate = 0; end
      end
    end
    #1;
    chk("slow_req", 32'(SlowReq), 32'(m_slow));
    chk("clock_gate", 32'(ClockGate), 32'(m_gate));
    chk("hold_cnt", 32'(HoldCnt), 32'(m_rem));
  endtask

  task automatic wait_ticks(input int n);
    int target, budget;
    target = m_ticks + n;
    budget = n * (1 << PSC) * 2 + 16;
    TimerTick = 1'b1;
    while (m_ticks < target && budget > 0) begin
      step();
      budget--;
    end
    TimerTick = 1'b0;
    if (m_ticks < target) chk("tick_budget", 32'(m_ticks), 32'(target));
  endtask

  task automatic clear_bus();
    bus_if.BACT = 0; bus_if.IACKCS = 0; bus_if.VIACS = 0; bus_if.IWMCS = 0;
    bus_if.SCCCS = 0; bus_if.SCSICS = 0; bus_if.SndCSWR = 0;
  endtask

  initial begin
    clear_bus();
    POR = 1; TimerTick = 0; SlowClockGate = 0; SlowTimeout = 0;
    {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = '0;
    m_ticks = 0;

    // Reset
    step(); step();
    chk("rst_req", 32'(SlowReq), 32'd0);
    chk("rst_cnt", 32'(HoldCnt), 32'd0);
    POR = 0;
    step();

    // VIA access with timeout 2: window of 47 ticks, ticks ignored during the access
    SlowVIA = 1; SlowTimeout = 4'h2;
    bus_if.BACT = 1; bus_if.VIACS = 1;
    for (int i = 0; i < 4; i++) begin
      TimerTick = i[0];
      step();
      chk("acc_frozen", 32'(HoldCnt), 32'h2F);
    end
    clear_bus(); TimerTick = 0;
    step();
    wait_ticks(46);
    chk("before_last", 32'(SlowReq), 32'd1);
    wait_ticks(1);
    chk("after_last", 32'(SlowReq), 32'd0);
    step();

    // Disabled SCC never triggers; timeout 0 covers only the access
    SlowSCC = 0;
    bus_if.BACT = 1; bus_if.SCCCS = 1;
    step(); step();
    chk("scc_off", 32'(SlowReq), 32'd0);
    clear_bus(); step();
    SlowTimeout = 0;
    bus_if.BACT = 1; bus_if.VIACS = 1;
    step(); step(); step();
    chk("to0_during", 32'(SlowReq), 32'd1);
    clear_bus(); step();
    chk("to0_after", 32'(SlowReq), 32'd0);

    // Reload from HOLD at count 5, hit coincident with a tick
    SlowIWM = 1; SlowTimeout = 4'h1;
    bus_if.BACT = 1; bus_if.IWMCS = 1;
    step(); step();
    clear_bus(); step();
    wait_ticks(26);
    chk("hold5", 32'(HoldCnt), 32'h05);
    bus_if.BACT = 1; bus_if.IWMCS = 1; TimerTick = 1;
    step();
    chk("reload", 32'(HoldCnt), 32'h1F);
    TimerTick = 0; step();
    clear_bus(); step();
    wait_ticks(31);
    chk("reload_end", 32'(SlowReq), 32'd0);

    // Gate captured at trigger; POR aborts the window
    SlowClockGate = 1;
    bus_if.BACT = 1; bus_if.VIACS = 1;
    step(); step();
    clear_bus(); step();
    SlowClockGate = 0;
    wait_ticks(10);
    chk("gate_held", 32'(ClockGate), 32'd1);
    POR = 1; step();
    chk("por_req", 32'(SlowReq), 32'd0);
    chk("por_gate", 32'(ClockGate), 32'd0);
    POR = 0; step();

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 3) == 0) bus_if.BACT = ~bus_if.BACT;
      {bus_if.IACKCS, bus_if.VIACS, bus_if.IWMCS, bus_if.SCCCS, bus_if.SCSICS, bus_if.SndCSWR}
        = 6'($urandom);
      if ($urandom_range(0, 15) == 0)
        {SlowIACK, SlowVIA, SlowIWM, SlowSCC, SlowSCSI, SlowSnd} = 6'($urandom);
      SlowTimeout   = 4'($urandom_range(0, 2));
      SlowClockGate = 1'($urandom);
      TimerTick     = 1'($urandom);
      POR           = ($urandom_range(0, 299) == 0);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
